// File: rtl/pll_phase_stepper.sv
// Dynamic phase-shift sequencer for the ECP5 EHXPLLL phasesel/phasedir/phasestep pins.
// Define PLL_PHASE_LOADREG_EN to add a phaseloadreg pulse (LOAD state) after each sequence.
module pll_phase_stepper #(
    parameter int STEP_W       = 8,
    parameter int POS_W        = 8,
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 1,
    parameter int GAP_CYCLES   = 1
`ifdef PLL_PHASE_LOADREG_EN
    ,
    parameter int LOAD_CYCLES  = 1
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 locked,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_sel,
    input  logic                 req_dir,
    input  logic [STEP_W-1:0]    req_steps,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [4*POS_W-1:0]   pos,
    output logic [1:0]           phasesel,
    output logic                 phasedir,
    output logic                 phasestep,
    output logic                 phaseloadreg
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
`ifdef PLL_PHASE_LOADREG_EN
    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(LOAD_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
`ifdef PLL_PHASE_LOADREG_EN
        ,
        S_LOAD  = 3'd5
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STEP_W-1:0]  rem_q, rem_d;
    logic               lost_q, lost_d;
    logic [1:0]         phasesel_q, phasesel_d;
    logic               phasedir_q, phasedir_d;
    logic               phasestep_q, phasestep_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [POS_W-1:0]   pos_q [4];
    logic [POS_W-1:0]   pos_d [4];
    logic               accept;
    logic               step_end;
    logic               abort;

    assign req_ready = (state_q == S_IDLE) & locked & ~rst;
    assign accept    = req_valid & req_ready;
    assign step_end  = (state_q == S_PULSE) && (cnt_q == PULSE_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            lost_q      <= 1'b0;
            phasesel_q  <= '0;
            phasedir_q  <= 1'b0;
            phasestep_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                pos_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            lost_q      <= lost_d;
            phasesel_q  <= phasesel_d;
            phasedir_q  <= phasedir_d;
            phasestep_q <= phasestep_d;
            done_q      <= done_d;
            err_q       <= err_d;
            for (int i = 0; i < 4; i++) begin
                pos_q[i] <= pos_d[i];
            end
        end
    end

    // Next-state logic; a pulse in flight always completes before an abort
    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (req_steps == '0) ? S_DONE : S_SETUP;
                end
            end
            S_SETUP: begin
                if (!locked) begin
                    state_d = S_DONE;
                    abort   = 1'b1;
                end else if (cnt_q == SETUP_LAST) begin
                    state_d = S_PULSE;
                end
            end
            S_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    if (lost_q || !locked) begin
                        state_d = S_DONE;
                        abort   = 1'b1;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (!locked) begin
                    state_d = S_DONE;
                    abort   = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    if (rem_q != '0) begin
                        state_d = S_PULSE;
                    end else begin
`ifdef PLL_PHASE_LOADREG_EN
                        state_d = S_LOAD;
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end
`ifdef PLL_PHASE_LOADREG_EN
            S_LOAD: begin
                if (cnt_q == LOAD_LAST) begin
                    state_d = S_DONE;
                    abort   = lost_q || !locked;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath: dwell counter, remaining steps, lock-loss latch, positions
    always_comb begin
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        lost_d     = lost_q;
        phasesel_d = phasesel_q;
        phasedir_d = phasedir_q;
        pos_d      = pos_q;
        if (state_q == S_IDLE || state_d != state_q) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (accept) begin
            rem_d      = req_steps;
            lost_d     = 1'b0;
            phasesel_d = req_sel;
            phasedir_d = req_dir;
        end
        if (!locked && state_q == S_PULSE) begin
            lost_d = 1'b1;
        end
`ifdef PLL_PHASE_LOADREG_EN
        if (!locked && state_q == S_LOAD) begin
            lost_d = 1'b1;
        end
`endif
        if (step_end) begin
            rem_d = rem_q - STEP_W'(1);
            if (phasedir_q) begin
                pos_d[phasesel_q] = pos_q[phasesel_q] - POS_W'(1);
            end else begin
                pos_d[phasesel_q] = pos_q[phasesel_q] + POS_W'(1);
            end
        end
    end

    // Output logic: registered from the upcoming state
    always_comb begin
        phasestep_d = (state_d == S_PULSE);
        done_d      = (state_d == S_DONE);
        err_d       = (state_d == S_DONE) && abort;
    end

`ifdef PLL_PHASE_LOADREG_EN
    logic phaseloadreg_q, phaseloadreg_d;

    always_comb begin
        phaseloadreg_d = (state_d == S_LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phaseloadreg_q <= 1'b0;
        end else begin
            phaseloadreg_q <= phaseloadreg_d;
        end
    end

    assign phaseloadreg = phaseloadreg_q;
`else
    assign phaseloadreg = 1'b0;
`endif

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign phasesel  = phasesel_q;
    assign phasedir  = phasedir_q;
    assign phasestep = phasestep_q;

    for (genvar g = 0; g < 4; g++) begin : g_pos
        assign pos[g*POS_W +: POS_W] = pos_q[g];
    end

endmodule

// File: tb/tb_pll_phase_stepper.sv
// Bench for pll_phase_stepper: vector table, corner sequences and random
// requests checked against a timeline model of the step sequencer.
module tb_pll_phase_stepper;

`ifdef PLL_PHASE_LOADREG_EN
    localparam int LD = 1;
`else
    localparam int LD = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        locked = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_sel = '0;
    logic        req_dir = 1'b0;
    logic [7:0]  req_steps = '0;
    logic        req_ready, busy, done, err;
    logic [31:0] pos;
    logic [1:0]  phasesel;
    logic        phasedir, phasestep, phaseloadreg;

    logic        lk2 = 1'b1;
    logic        r2_valid = 1'b0;
    logic [1:0]  r2_sel = '0;
    logic        r2_dir = 1'b0;
    logic [7:0]  r2_steps = '0;
    logic        req_ready2, busy2, done2, err2;
    logic [31:0] pos2;
    logic [1:0]  phasesel2;
    logic        phasedir2, phasestep2, phaseloadreg2;

    pll_phase_stepper dut (
        .clk(clk), .rst(rst), .locked(locked),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_sel(req_sel), .req_dir(req_dir), .req_steps(req_steps),
        .busy(busy), .done(done), .err(err), .pos(pos),
        .phasesel(phasesel), .phasedir(phasedir),
        .phasestep(phasestep), .phaseloadreg(phaseloadreg)
    );

    pll_phase_stepper #(
        .SETUP_CYCLES(2), .PULSE_CYCLES(3), .GAP_CYCLES(2)
    ) dut2 (
        .clk(clk), .rst(rst), .locked(lk2),
        .req_valid(r2_valid), .req_ready(req_ready2),
        .req_sel(r2_sel), .req_dir(r2_dir), .req_steps(r2_steps),
        .busy(busy2), .done(done2), .err(err2), .pos(pos2),
        .phasesel(phasesel2), .phasedir(phasedir2),
        .phasestep(phasestep2), .phaseloadreg(phaseloadreg2)
    );

    always #20 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] pm [4];
    int hi_q[$];
    int ld_q[$];

    typedef struct {
        logic [1:0] sel;
        logic       dir;
        int         steps;
        int         drop;
        int         np;
        int         dn;
        logic       ev;
        logic [7:0] p;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pm_vec();
        return {pm[3], pm[2], pm[1], pm[0]};
    endfunction

    // drop = cycle offset after accept during which locked is held low (0 = never)
    task automatic run(input logic [1:0] sel, input logic dir, input int steps,
                       input int drop, output int npul, output int dn,
                       output logic ev);
        npul = 0;
        dn = -1;
        ev = 1'b0;
        hi_q.delete();
        ld_q.delete();
        @(posedge clk); #1;
        for (int w = 0; w < 20 && !req_ready; w++) begin
            @(posedge clk); #1;
        end
        chk("ready_before_req", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_sel   = sel;
        req_dir   = dir;
        req_steps = 8'(steps);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int d = 1; d <= 2 * steps + 12; d++) begin
            locked = (d != drop);
            @(negedge clk);
            if (d == 1) begin
                chk("sel_dir_latched", {29'b0, phasesel, phasedir}, {29'b0, sel, dir});
                chk("busy_after_accept", {31'b0, busy}, 32'd1);
            end
            if (phasestep) begin
                hi_q.push_back(d);
                npul++;
            end
            if (phaseloadreg) ld_q.push_back(d);
            if (done) begin
                dn = d;
                ev = err;
                break;
            end
            @(posedge clk); #1;
        end
        locked = 1'b1;
    endtask

    task automatic do_txn(input logic [1:0] sel, input logic dir, input int steps,
                          input int drop, input int enp, input int edn,
                          input logic eev, input int eld, input logic [7:0] ep);
        int np, dn, bad;
        logic ev;
        run(sel, dir, steps, drop, np, dn, ev);
        bad = 0;
        foreach (hi_q[i]) if (hi_q[i] != 2 * (i + 1)) bad = 1;
        chk("pulse_count", np, enp);
        chk("pulse_timing", bad, 0);
        chk("done_offset", dn, edn);
        chk("err", {31'b0, ev}, {31'b0, eev});
        chk("load_count", ld_q.size(), (eld < 0) ? 0 : 1);
        if (eld >= 0 && ld_q.size() > 0) chk("load_offset", ld_q[0], eld);
        pm[sel] = ep;
        chk("pos", pos, pm_vec());
    endtask

    // Spec timeline at 1/1/1: setup at +1, pulse k at +2k, gap at +2k+1
    task automatic model(input int steps, input int drop, output int np,
                         output int dn, output logic ev, output int ld);
        ld = -1;
        if (steps == 0) begin
            np = 0; dn = 1; ev = 1'b0;
        end else if (drop == 0) begin
            np = steps; ev = 1'b0;
            dn = 2 * steps + 2 + LD;
            if (LD != 0) ld = 2 * steps + 2;
        end else begin
            np = drop / 2; dn = drop + 1; ev = 1'b1;
        end
    endtask

    initial begin
        int np, dn, ld, v, hi2_d;
        logic ev;
        logic [31:0] hi2;
        for (int i = 0; i < 4; i++) pm[i] = '0;

        tbl[0] = '{2'd2, 1'b0, 3, 0, 3, 8, 1'b0, 8'h03};
        tbl[1] = '{2'd1, 1'b1, 0, 0, 0, 1, 1'b0, 8'h00};
        tbl[2] = '{2'd3, 1'b0, 5, 4, 2, 5, 1'b1, 8'h02};
        tbl[3] = '{2'd1, 1'b1, 2, 0, 2, 6, 1'b0, 8'hFE};
        tbl[4] = '{2'd0, 1'b0, 1, 1, 0, 2, 1'b1, 8'h00};
        tbl[5] = '{2'd2, 1'b1, 4, 5, 2, 6, 1'b1, 8'h01};
        tbl[6] = '{2'd0, 1'b1, 1, 2, 1, 3, 1'b1, 8'hFF};
        tbl[7] = '{2'd3, 1'b1, 2, 5, 2, 6, 1'b1, 8'h00};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_flags", {26'b0, busy, done, err, phasestep, phaseloadreg, req_ready}, 32'd0);
        chk("rst_pos", pos, 32'd0);
        chk("rst_sel_dir", {29'b0, phasesel, phasedir}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {30'b0, req_ready, busy}, 32'd2);

        foreach (tbl[k]) begin
            int edn, eld;
            edn = tbl[k].dn;
            eld = -1;
            if (!tbl[k].ev && tbl[k].steps != 0) begin
                edn = edn + LD;
                if (LD != 0) eld = 2 * tbl[k].steps + 2;
            end
            do_txn(tbl[k].sel, tbl[k].dir, tbl[k].steps, tbl[k].drop,
                   tbl[k].np, edn, tbl[k].ev, eld, tbl[k].p);
        end

        @(posedge clk); #1;
        locked = 1'b0;
        @(negedge clk);
        chk("ready_unlocked", {31'b0, req_ready}, 32'd0);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        locked = 1'b1;
        @(negedge clk);
        chk("unlocked_req_ignored", {31'b0, busy}, 32'd0);

        @(posedge clk); #1;
        req_valid = 1'b1; req_sel = 2'd2; req_dir = 1'b0; req_steps = 8'd4;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int d = 0; d < 10 && !phasestep; d++) begin
            @(posedge clk); #1;
        end
        chk("midseq_pulse_seen", {31'b0, phasestep}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midseq_rst_flags", {29'b0, busy, phasestep, done}, 32'd0);
        chk("midseq_rst_pos", pos, 32'd0);
        for (int i = 0; i < 4; i++) pm[i] = '0;

        do_txn(2'd0, 1'b1, 128, 0, 128, 258 + LD, 1'b0, LD ? 258 : -1, 8'h80);
        do_txn(2'd0, 1'b1, 1, 0, 1, 4 + LD, 1'b0, LD ? 4 : -1, 8'h7F);

        @(posedge clk); #1;
        chk("dut2_ready", {31'b0, req_ready2}, 32'd1);
        r2_valid = 1'b1; r2_sel = 2'd1; r2_dir = 1'b0; r2_steps = 8'd2;
        @(posedge clk); #1;
        r2_valid = 1'b0;
        hi2 = '0;
        hi2_d = -1;
        ev = 1'b1;
        for (int d = 1; d <= 30; d++) begin
            r2_valid = (d == 4);
            r2_sel = 2'd3;
            r2_steps = 8'd7;
            @(negedge clk);
            if (d == 4) chk("dut2_ready_busy", {31'b0, req_ready2}, 32'd0);
            if (phasestep2) hi2[d] = 1'b1;
            if (done2) begin
                hi2_d = d;
                ev = err2;
                break;
            end
            @(posedge clk); #1;
        end
        r2_valid = 1'b0;
        chk("dut2_pulse_map", hi2, 32'h0000_0738);
        chk("dut2_done", hi2_d, 13 + LD);
        chk("dut2_err", {31'b0, ev}, 32'd0);
        chk("dut2_pos", pos2, 32'h0000_0200);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("dut2_no_queue", {29'b0, busy2, phasesel2}, 32'd1);
        chk("dut2_pos_hold", pos2, 32'h0000_0200);

        for (int t = 0; t < 40; t++) begin
            int steps, drop;
            logic [1:0] sel;
            logic dir;
            sel = 2'($urandom_range(0, 3));
            dir = 1'($urandom_range(0, 1));
            steps = $urandom_range(0, 12);
            drop = 0;
            if (steps > 0 && $urandom_range(0, 2) == 0)
                drop = $urandom_range(1, 2 * steps + 1);
            model(steps, drop, np, dn, ev, ld);
            v = int'(pm[sel]) + (dir ? -np : np);
            do_txn(sel, dir, steps, drop, np, dn, ev, ld, 8'(v));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_phase_stepper.md
Name: pll_phase_stepper

Overview:
- Sequencer sitting directly upstream of the ECP5 EHXPLLL wrapper's dynamic phase-shift pins.
- Turns a "shift clkout N by K steps in direction D" request into correctly timed phasesel/phasedir/phasestep pulses.
- Tracks the accumulated phase offset, in 45-degree steps, for each of the four PLL outputs.
- Runs in a slow fabric clock domain (e.g. 25 MHz); all PLL timing minimums (5 ns setup, 5 ns step high) are met by whole-cycle counts.

Parameters:
- STEP_W, 8, width of the requested step count.
- POS_W, 8, width of each per-output signed phase position counter (wraps two's complement).
- SETUP_CYCLES, 1, cycles phasesel/phasedir are held stable before the first phasestep rise (min 1).
- PULSE_CYCLES, 1, cycles phasestep is held high (min 1).
- GAP_CYCLES, 1, cycles phasestep is held low between pulses (min 1).

Ports:
- clk  in  1  fabric clock
- rst  in  1  synchronous reset, active-high
- locked  in  1  PLL lock
- req_valid  in  1  request strobe
- req_ready  out  1  high when idle and locked
- req_sel  in  2  logical clkout index 0..3; the PLL wrapper performs the hardware index mapping
- req_dir  in  1  0 = delay (lagging), 1 = advance (leading)
- req_steps  in  STEP_W  number of 45-degree steps
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at end of sequence
- err  out  1  valid with done; 1 = aborted by lock loss
- pos  out  4*POS_W  signed offsets; clkout n at bits [n*POS_W +: POS_W]
- phasesel  out  2  to PLL
- phasedir  out  1  to PLL
- phasestep  out  1  to PLL
- phaseloadreg  out  1  to PLL

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high; port names are clk and rst.
- Reset values: all outputs 0, pos all 0, state IDLE. Reset mid-sequence drops phasestep the next edge; that partial pulse is tolerated.
- Output registration: all PLL-facing outputs are registered directly from flops.
- req_ready = (state == IDLE) & locked & ~rst.
- Accept: on the edge where req_valid & req_ready, capture sel/dir/steps; phasesel/phasedir update on that edge. phasesel/phasedir are held constant until the next accept.
- States: IDLE, SETUP, PULSE, GAP, DONE (plus LOAD, see Optional Feature).
- IDLE -> SETUP on accept; if req_steps == 0, go IDLE -> DONE directly with no pulse and err = 0.
- SETUP: lasts SETUP_CYCLES, then -> PULSE.
- PULSE: phasestep = 1 for PULSE_CYCLES, then -> GAP. On leaving PULSE:
  - decrement the remaining-step count;
  - pos[sel] += 1 if dir == 0, else pos[sel] -= 1, wrapping modulo 2^POS_W.
- GAP: phasestep = 0 for GAP_CYCLES. Then -> PULSE if remaining != 0, else -> DONE.
- DONE: done = 1 for exactly one cycle, then -> IDLE.
- busy = 1 in every state except IDLE.
- Latency with defaults 1/1/1: accept at edge T gives phasestep high during cycles T+2, T+4, ..., T+2N and done during cycle T+2+2N.
- Lock loss, locked = 0 sampled in SETUP or GAP: -> DONE with err = 1, remaining steps discarded.
- Lock loss in PULSE: the pulse completes its full width and pos updates, then -> DONE with err = 1. A pulse is never truncated.
- req_valid while busy: ignored (ready = 0), no queuing.
- phaseloadreg = 0 when the feature is absent.

Optional Feature:
- Macro: PLL_PHASE_LOADREG_EN.
- When defined:
  - After the last GAP of a non-aborted sequence with req_steps != 0, enter LOAD.
  - In LOAD, phaseloadreg = 1 for max(1, ceil(10 ns / clk period)) cycles, set by a LOAD_CYCLES parameter with default 1. Then -> DONE.
  - Lock loss during LOAD still completes the pulse and sets err = 1.
  - Adds LOAD_CYCLES to the latency.
- When undefined: no LOAD state, no LOAD_CYCLES parameter, phaseloadreg tied 0.

Test Plan:
1. Reset check: assert rst 3 cycles with locked = 1 -> all outputs 0, pos = 0; req_ready = 1 on the first cycle after rst falls.
2. Basic sequence: defaults; request sel = 2, dir = 0, steps = 3 accepted at T -> phasesel = 2 from T+1; phasestep high exactly at T+2, T+4, T+6; done at T+8 with err = 0; pos[2] = +3; other pos unchanged.
3. Advance with wrap: preload pos[0] = -128 via 128 advance-direction steps on sel = 0 (dir = 1) -> pos[0] = 0x80. One further dir = 1 step -> pos[0] = 0x7F. Separately, sel = 1, dir = 1, steps = 0 -> done one cycle after accept, no phasestep edges.
4. Lock loss: steps = 5; drop locked during the 2nd PULSE -> that pulse stays full width; no 3rd pulse; done with err = 1; pos[sel] = +2.
5. Busy rejection and custom timing: SETUP_CYCLES = 2, PULSE_CYCLES = 3, GAP_CYCLES = 2; pulse req_valid while busy -> ignored. Measure: 2-cycle setup, 3-cycle high, 2-cycle low between pulses.
6. With PLL_PHASE_LOADREG_EN, steps = 1 -> one phasestep pulse, then phaseloadreg high 1 cycle, then done. With steps = 0 -> no phaseloadreg.
